// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bi.
// Borrow out is set when x < y + bi.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // pure combinational difference and borrow
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first.
// A single borrow flop chains state across bits.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor_bit u_fs (
    .x  (sh_a[0]),
    .y  (sh_b[0]),
    .bi (br),
    .d  (d),
    .bo (bo)
  );

  // result register with the current difference bit shifted in
  always_comb begin
    res_nxt = {d, res[WIDTH-1:1]};
  end

  // FSM, shift registers, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            res   <= '0;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_nxt;
          br   <= bo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_nxt;
            bout  <= bo;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor.
// Expected values are hand-computed two's-complement differences.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int obs, input int exp, input string tag);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input logic [7:0] ta,
    input logic [7:0] tb_v,
    input logic       tbi,
    input logic [7:0] ed,
    input logic       eb,
    input string      tag
  );
    int n;
    int bc;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbi; start = 1'b1;
    @(posedge clk);
    n = 0; bc = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) seen = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk(int'(seen), 1, {tag, "_done_seen"});
    chk(n, 8, {tag, "_latency"});
    chk(bc, 8, {tag, "_busy_cycles"});
    chk(int'(diff), int'(ed), {tag, "_diff"});
    chk(int'(bout), int'(eb), {tag, "_bout"});
    @(negedge clk);
    chk(int'(done), 0, {tag, "_done_pulse_width"});
  endtask

  initial begin
    int t1;
    int t2;
    int cnt;
    bit seen;
    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk(int'(busy), 0, "rst_busy");
    chk(int'(done), 0, "rst_done");
    chk(int'(diff), 0, "rst_diff");
    chk(int'(bout), 0, "rst_bout");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "5a_3c");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "00_01");
    run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "10_0f_b1");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "00_00_b1");

    // start while busy is ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk(int'(diff), 8'hFF, "ign_diff_stable");
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk(cnt, 1, "ign_done_count");
    chk(int'(diff), 8'h1E, "ign_diff");
    chk(int'(bout), 0, "ign_bout");

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h01; b = 8'h02;
    seen = 0; t1 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        t1 = cyc;
      end
    end
    chk(int'(seen), 1, "b2b_first_done");
    chk(int'(diff), 8'h7F, "b2b_first_diff");
    chk(int'(bout), 0, "b2b_first_bout");
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 0; t2 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1;
        t2 = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk(int'(seen), 1, "b2b_second_done");
    chk(int'(diff), 8'hFF, "b2b_second_diff");
    chk(int'(bout), 1, "b2b_second_bout");
    chk(t2 - t1, 9, "b2b_spacing");

    // asynchronous reset mid-shift
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(int'(busy), 0, "arst_busy");
    chk(int'(done), 0, "arst_done");
    chk(int'(diff), 0, "arst_diff");
    chk(int'(bout), 0, "arst_bout");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk(cnt, 0, "arst_no_done");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
